pulse_skew_meas: RTL and testbench
==================================

PULSE_SKEW_MEAS -- requirements
Module: pulse_skew_meas

Interface
REQ-001 SHALL have parameter MAX_DLY, default 3, meaning the largest measurable skew in cycles (legal 1..15).
REQ-002 SHALL have derived localparam CW = $clog2(MAX_DLY+1), meaning the width of the skew result.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle request to arm one measurement.
REQ-006 SHALL have port ref_pulse, input, 1, the undelayed reference pulse.
REQ-007 SHALL have port dly_pulse, input, 1, the delayed pulse under test (the pulse-delay block output).
REQ-008 SHALL have port skew, output, CW, the measured delay in cycles, ready as the sel value for the pulse-delay block.
REQ-009 SHALL have port skew_vld, output, 1, a level that means skew holds a valid result.
REQ-010 SHALL have port err, output, 1, a level that means the last measurement timed out.
REQ-011 SHALL have port busy, output, 1, which means a measurement is in progress.
REQ-012 SHALL have port lock, output, 1, which means the skew is stable (see Configuration).

Function
REQ-013 SHALL use FSM states IDLE, WAIT_REF and COUNT, encoded as a package enum.
REQ-014 SHALL, in IDLE, move to WAIT_REF on start, clear skew_vld and err, and hold skew at its old value.
REQ-015 SHALL, in WAIT_REF, on ref_pulse with dly_pulse high in the same cycle, load skew=0, set skew_vld, and go to IDLE.
REQ-016 SHALL, in WAIT_REF, on ref_pulse with dly_pulse low, load cnt=1 and go to COUNT.
REQ-017 SHALL ignore dly_pulse in WAIT_REF when ref_pulse is low (a stale pulse).
REQ-018 SHALL, in COUNT, on dly_pulse, load skew=cnt, set skew_vld, and go to IDLE.
REQ-019 SHALL, in COUNT, with dly_pulse low and cnt==MAX_DLY, set err, leave skew unchanged, and go to IDLE.
REQ-020 SHALL, in COUNT, with no dly_pulse and cnt<MAX_DLY, increment cnt; cnt never wraps.
REQ-021 SHALL make skew/skew_vld/err visible on the cycle after the deciding input is sampled (registered outputs, latency 1).
REQ-022 SHALL drive busy high exactly when the state is not IDLE (registered).
REQ-023 SHALL ignore start while busy, and ignore ref_pulse while in COUNT.
REQ-024 SHALL never have skew_vld and err high at the same time.

Reset
REQ-025 SHALL, on rst, force state=IDLE, cnt=0, skew=0, skew_vld=0, err=0, busy=0 and lock=0.
REQ-026 SHALL let rst mid-measurement abort it with no result produced, and let rst override start in the same cycle.

Configuration
REQ-027 SHALL use macro PULSE_SKEW_LOCK_EN to select the lock behaviour.
REQ-028 SHALL, with PULSE_SKEW_LOCK_EN defined, keep last_skew and set lock when two consecutive successful measurements give equal skew.
REQ-029 SHALL, with PULSE_SKEW_LOCK_EN defined, clear lock on err, on an unequal result, or on rst, and hold lock through start.
REQ-030 SHALL, without PULSE_SKEW_LOCK_EN, drive lock = skew_vld and include no last_skew register.

Structure
REQ-031 SHALL place the state enum typedef and the default MAX_DLY constant in package pulse_skew_pkg.
REQ-032 SHALL use no sub-module; the counter and FSM are inline in one module.

Verification
REQ-033 SHALL test: start, ref_pulse at T, dly_pulse at T+2 -> skew=2 and skew_vld=1 at T+3, with busy low at T+3.
REQ-034 SHALL test: start, ref_pulse and dly_pulse in the same cycle T -> skew=0 and skew_vld=1 at T+1.
REQ-035 SHALL test: start, ref_pulse at T, no dly_pulse (MAX_DLY=3) -> err=1 at T+4, skew_vld=0, skew unchanged.
REQ-036 SHALL test: dly_pulse before ref_pulse, then ref at T and dly at T+1 -> skew=1 and no early result.
REQ-037 SHALL test: rst pulsed in COUNT -> all outputs 0 next cycle, and a later dly_pulse produces no result.
REQ-038 SHALL test with macro defined: measurements 2, 2, 3, then a timeout -> lock sequence 0, 1, 0, 0.

Source files
------------

// File: rtl/pulse_skew_pkg.sv
// Shared types and defaults for the pulse skew measurement block.
package pulse_skew_pkg;

  localparam int MAX_DLY_DEF = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REF = 2'd1,
    COUNT    = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_skew_meas.sv
// Measures the cycle skew between ref_pulse and dly_pulse for use as a delay select.
// Optional macro PULSE_SKEW_LOCK_EN: lock asserts on two consecutive equal measurements.
//
// state    | meaning
// IDLE     | no measurement running; result outputs hold
// WAIT_REF | armed, waiting for the reference pulse
// COUNT    | reference seen, counting cycles until dly_pulse or timeout
module pulse_skew_meas
  import pulse_skew_pkg::*;
#(
  parameter int MAX_DLY = MAX_DLY_DEF,
  localparam int CW = $clog2(MAX_DLY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ref_pulse,
  input  logic          dly_pulse,
  output logic [CW-1:0] skew,
  output logic          skew_vld,
  output logic          err,
  output logic          busy,
  output logic          lock
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DLY);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          done_ok;
  logic          done_err;
  logic [CW-1:0] meas;

  // Decode the deciding cycle of a measurement; shared by the FSM and the lock tracker.
  always_comb begin
    done_ok  = 1'b0;
    done_err = 1'b0;
    meas     = cnt;
    case (state)
      WAIT_REF: begin
        if (ref_pulse && dly_pulse) begin
          done_ok = 1'b1;
          meas    = '0;
        end
      end
      COUNT: begin
        if (dly_pulse) begin
          done_ok = 1'b1;
        end else if (cnt == CNT_MAX) begin
          done_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      skew     <= '0;
      skew_vld <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT_REF;
            busy     <= 1'b1;
            skew_vld <= 1'b0;
            err      <= 1'b0;
          end
        end
        WAIT_REF: begin
          if (done_ok) begin
            skew     <= meas;
            skew_vld <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end else if (ref_pulse) begin
            cnt   <= CW'(1);
            state <= COUNT;
          end
        end
        COUNT: begin
          if (done_ok) begin
            skew     <= meas;
            skew_vld <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end else if (done_err) begin
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PULSE_SKEW_LOCK_EN
  logic [CW-1:0] last_skew;
  logic          last_vld;

  // last_vld breaks the chain on a timeout so a stale value cannot lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_skew <= '0;
      last_vld  <= 1'b0;
      lock      <= 1'b0;
    end else if (done_ok) begin
      lock      <= last_vld && (last_skew == meas);
      last_skew <= meas;
      last_vld  <= 1'b1;
    end else if (done_err) begin
      lock     <= 1'b0;
      last_vld <= 1'b0;
    end
  end
`else
  assign lock = skew_vld;
`endif

endmodule

// File: tb/tb_pulse_skew_meas.sv
// Directed self-checking bench for pulse_skew_meas (MAX_DLY = 3).
module tb_pulse_skew_meas;

  localparam int MAX_DLY = 3;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          ref_pulse;
  logic          dly_pulse;
  logic [CW-1:0] skew;
  logic          skew_vld;
  logic          err;
  logic          busy;
  logic          lock;

  int n_pass;
  int n_total;

  pulse_skew_meas #(.MAX_DLY(MAX_DLY)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ref_pulse(ref_pulse),
    .dly_pulse(dly_pulse),
    .skew     (skew),
    .skew_vld (skew_vld),
    .err      (err),
    .busy     (busy),
    .lock     (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arm, fire ref, then either dly after d cycles or let it time out.
  task automatic run_meas(input int d, input bit to);
    start = 1'b1;
    step();
    start     = 1'b0;
    ref_pulse = 1'b1;
    dly_pulse = (d == 0 && !to);
    step();
    ref_pulse = 1'b0;
    dly_pulse = 1'b0;
    if (to) begin
      repeat (MAX_DLY) step();
    end else if (d > 0) begin
      repeat (d - 1) step();
      dly_pulse = 1'b1;
      step();
      dly_pulse = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if ({skew, skew_vld, err, busy, lock} !== 6'b0)
      $display("FAIL reset_outputs got skew=%0d vld=%b err=%b busy=%b lock=%b want all 0", skew, skew_vld, err, busy, lock);
    else n_pass++;
  endtask

  task automatic test_skew2();
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL skew2_busy_armed got %b want 1", busy); else n_pass++;
    ref_pulse = 1'b1;
    step();
    ref_pulse = 1'b0;
    step();
    n_total++; if (skew_vld !== 1'b0 || busy !== 1'b1)
      $display("FAIL skew2_midway got vld=%b busy=%b want 0 1", skew_vld, busy);
    else n_pass++;
    dly_pulse = 1'b1;
    step();
    dly_pulse = 1'b0;
    n_total++; if (skew !== 2'd2) $display("FAIL skew2_value got %0d want 2", skew); else n_pass++;
    n_total++; if (skew_vld !== 1'b1 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL skew2_flags got vld=%b err=%b busy=%b want 1 0 0", skew_vld, err, busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    run_meas(0, 1'b1);
    n_total++; if (err !== 1'b1 || skew_vld !== 1'b0 || busy !== 1'b0)
      $display("FAIL timeout_flags got err=%b vld=%b busy=%b want 1 0 0", err, skew_vld, busy);
    else n_pass++;
    n_total++; if (skew !== 2'd2) $display("FAIL timeout_skew_held got %0d want 2", skew); else n_pass++;
  endtask

  task automatic test_early_timeout_edge();
    // One cycle before the timeout nothing may be reported yet.
    start = 1'b1;
    step();
    start     = 1'b0;
    ref_pulse = 1'b1;
    step();
    ref_pulse = 1'b0;
    repeat (MAX_DLY - 1) step();
    n_total++; if (err !== 1'b0 || busy !== 1'b1)
      $display("FAIL timeout_not_early got err=%b busy=%b want 0 1", err, busy);
    else n_pass++;
    step();
    n_total++; if (err !== 1'b1) $display("FAIL timeout_edge got err=%b want 1", err); else n_pass++;
  endtask

  task automatic test_skew0();
    run_meas(0, 1'b0);
    n_total++; if (skew !== 2'd0 || skew_vld !== 1'b1 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL skew0 got skew=%0d vld=%b err=%b busy=%b want 0 1 0 0", skew, skew_vld, err, busy);
    else n_pass++;
  endtask

  task automatic test_max_skew();
    run_meas(MAX_DLY, 1'b0);
    n_total++; if (skew !== 2'd3 || skew_vld !== 1'b1 || err !== 1'b0)
      $display("FAIL max_skew got skew=%0d vld=%b err=%b want 3 1 0", skew, skew_vld, err);
    else n_pass++;
  endtask

  task automatic test_stale_dly();
    start = 1'b1;
    step();
    start     = 1'b0;
    dly_pulse = 1'b1;
    step();
    dly_pulse = 1'b0;
    n_total++; if (skew_vld !== 1'b0 || busy !== 1'b1)
      $display("FAIL stale_no_early got vld=%b busy=%b want 0 1", skew_vld, busy);
    else n_pass++;
    ref_pulse = 1'b1;
    step();
    ref_pulse = 1'b0;
    dly_pulse = 1'b1;
    step();
    dly_pulse = 1'b0;
    n_total++; if (skew !== 2'd1 || skew_vld !== 1'b1)
      $display("FAIL stale_skew1 got skew=%0d vld=%b want 1 1", skew, skew_vld);
    else n_pass++;
  endtask

  task automatic test_ignore_while_busy();
    // start and ref_pulse arriving mid-count must not restart the count.
    start = 1'b1;
    step();
    start     = 1'b0;
    ref_pulse = 1'b1;
    step();
    ref_pulse = 1'b1;
    start     = 1'b1;
    step();
    ref_pulse = 1'b0;
    start     = 1'b0;
    dly_pulse = 1'b1;
    step();
    dly_pulse = 1'b0;
    n_total++; if (skew !== 2'd2 || skew_vld !== 1'b1)
      $display("FAIL busy_ignore got skew=%0d vld=%b want 2 1", skew, skew_vld);
    else n_pass++;
  endtask

  task automatic test_rst_in_count();
    start = 1'b1;
    step();
    start     = 1'b0;
    ref_pulse = 1'b1;
    step();
    ref_pulse = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if ({skew, skew_vld, err, busy, lock} !== 6'b0)
      $display("FAIL rst_count_outputs got skew=%0d vld=%b err=%b busy=%b lock=%b want all 0", skew, skew_vld, err, busy, lock);
    else n_pass++;
    dly_pulse = 1'b1;
    step();
    dly_pulse = 1'b0;
    step();
    n_total++; if (skew_vld !== 1'b0 || busy !== 1'b0 || skew !== 2'd0)
      $display("FAIL rst_count_no_result got vld=%b busy=%b skew=%0d want 0 0 0", skew_vld, busy, skew);
    else n_pass++;
  endtask

  task automatic test_rst_over_start();
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    step();
    n_total++; if (busy !== 1'b0) $display("FAIL rst_over_start got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_lock();
    logic [3:0] exp_lock;
    logic [3:0] got_lock;
    do_reset();
    run_meas(2, 1'b0); got_lock[0] = lock;
    run_meas(2, 1'b0); got_lock[1] = lock;
    run_meas(3, 1'b0); got_lock[2] = lock;
    run_meas(0, 1'b1); got_lock[3] = lock;
`ifdef PULSE_SKEW_LOCK_EN
    exp_lock = 4'b0010;
`else
    exp_lock = 4'b0111;
`endif
    n_total++; if (got_lock !== exp_lock)
      $display("FAIL lock_sequence got %b want %b (bit0 first)", got_lock, exp_lock);
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    start     = 1'b0;
    ref_pulse = 1'b0;
    dly_pulse = 1'b0;
    repeat (2) step();
    test_reset();
    test_skew2();
    test_timeout();
    test_early_timeout_edge();
    test_skew0();
    test_max_skew();
    test_stale_dly();
    test_ignore_while_busy();
    test_rst_in_count();
    test_rst_over_start();
    test_lock();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
